demux_router: RTL and testbench

- Registered 1-to-4 stream demultiplexer; the distribution-side counterpart of the 2:1 mux trees in the mux library.
- Accepts one data word per handshake and steers it by a select field to one of four output streams.
- Each output has its own 2-entry FIFO, so a stalled consumer only blocks traffic addressed to it.
- Sits between a single producer and four independent consumers.

---
 rtl/demux_router_if.sv | 33 +++
 rtl/demux_router.sv | 82 ++++++++
 tb/tb_demux_router.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/demux_router_if.sv
// Stream bundle for the 1-to-4 demux router: one producer side and four consumer sides.
// The slave modport is the router's view; the master modport is the producer/consumer view.
interface demux_router_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/demux_router.sv
// Registered 1-to-4 stream demultiplexer with a 2-entry FIFO per output port,
// so a stalled consumer only blocks words addressed to it.
module demux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  demux_router_if.slave    bus,
  output logic [CNT_W-1:0] accept_cnt,
  output logic             busy
);

  logic [WIDTH-1:0] mem_q [4][2];
  logic [1:0]       cnt_q [4];
  logic [3:0]       wptr_q;
  logic [3:0]       rptr_q;
  logic [CNT_W-1:0] accept_cnt_q;

  logic       in_ready;
  logic       accept;
  logic [3:0] push;
  logic [3:0] pop;
  logic [3:0] out_valid;

  // Ready depends only on the addressed port's count; no pass-through when full.
  always_comb begin
    in_ready = !rst && (cnt_q[bus.in_sel] < 2'd2);
    accept   = bus.in_valid && in_ready;
    push     = '0;
    pop      = '0;
    out_valid = '0;
    bus.out_data = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (cnt_q[i] != 2'd0);
      push[i]      = accept && (bus.in_sel == 2'(i));
      pop[i]       = out_valid[i] && bus.out_ready[i];
      if (out_valid[i]) begin
        bus.out_data[i*WIDTH +: WIDTH] = mem_q[i][rptr_q[i]];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign busy          = |out_valid;
  assign accept_cnt    = accept_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      accept_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          wptr_q[i] <= ~wptr_q[i];
        end
        if (pop[i]) begin
          rptr_q[i] <= ~rptr_q[i];
        end
        cnt_q[i] <= cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
      if (accept && (accept_cnt_q != '1)) begin
        accept_cnt_q <= accept_cnt_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is masked by the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router (WIDTH=8, CNT_W=4 so saturation is reachable).
module tb_demux_router;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] accept_cnt;
  logic             busy;

  int checks;
  int errors;

  demux_router_if #(.WIDTH(WIDTH)) bus ();

  demux_router #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .accept_cnt (accept_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] data);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = data;
    #1;
  endtask

  function automatic logic [7:0] port_data(input int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd2, 8'hAA);

    // Reset holds in_ready low and nothing is pushed.
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_cnt", 32'(accept_cnt), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Basic routing: each word visible one cycle later on its own port only.
    bus.out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'(8'h11 * (k + 1)));
      check_eq("route_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_eq("route_onehot", 32'(bus.out_valid), 32'(4'b0001 << k));
      check_eq("route_data", 32'(port_data(k)), 32'(8'h11 * (k + 1)));
    end
    drive(1'b0, 2'd0, 8'h00);
    check_eq("route_cnt", 32'(accept_cnt), 32'd4);
    tick();
    check_eq("route_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure on port 1; port 3 stays independent.
    bus.out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'hA1);
    check_eq("bp_rdy_a1", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 2'd1, 8'hA2);
    check_eq("bp_rdy_a2", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 2'd1, 8'hA3);
    check_eq("bp_full", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("bp_head_a1", 32'(port_data(1)), 32'hA1);
    drive(1'b1, 2'd3, 8'hB0);
    check_eq("bp_rdy_b0", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("bp_valid_b0", 32'(bus.out_valid), 32'b1010);
    check_eq("bp_data_b0", 32'(port_data(3)), 32'hB0);
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'd1, 8'hA3);
    check_eq("bp_still_full", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("bp_valid_a2", 32'(bus.out_valid), 32'b0010);
    check_eq("bp_head_a2", 32'(port_data(1)), 32'hA2);
    check_eq("bp_rdy_a3", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("bp_head_a3", 32'(port_data(1)), 32'hA3);
    check_eq("bp_cnt", 32'(accept_cnt), 32'd8);
    tick();
    check_eq("bp_drained", 32'(bus.out_valid), 32'd0);

    // Same-cycle push and pop on port 2.
    bus.out_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'h50);
    tick();
    check_eq("pp_head_50", 32'(port_data(2)), 32'h50);
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'd2, 8'h51);
    check_eq("pp_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("pp_valid", 32'(bus.out_valid), 32'b0100);
    check_eq("pp_head_51", 32'(port_data(2)), 32'h51);
    tick();
    check_eq("pp_drained", 32'(bus.out_valid), 32'd0);
    check_eq("pp_cnt", 32'(accept_cnt), 32'd10);

    // Saturation: 20 accepts from a cleared counter, 4-bit counter caps at 15.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'(k % 4), 8'(k));
      tick();
      check_eq("sat_cnt", 32'(accept_cnt), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check_eq("sat_hold", 32'(accept_cnt), 32'd15);

    // Mid-stream reset discards queued words on ports 0 and 3.
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'hC0);
    tick();
    drive(1'b1, 2'd0, 8'hC1);
    tick();
    drive(1'b1, 2'd3, 8'hD0);
    tick();
    drive(1'b1, 2'd3, 8'hD1);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("mid_valid", 32'(bus.out_valid), 32'b1001);
    check_eq("mid_busy", 32'(busy), 32'd1);
    check_eq("mid_head3", 32'(port_data(3)), 32'hD0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cnt", 32'(accept_cnt), 32'd0);
    check_eq("mid_rst_data", bus.out_data, 32'd0);
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'd0, 8'h77);
    check_eq("post_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("post_valid", 32'(bus.out_valid), 32'b0001);
    check_eq("post_data", 32'(port_data(0)), 32'h77);
    check_eq("post_cnt", 32'(accept_cnt), 32'd1);
    tick();
    check_eq("post_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
